// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 VGA timing constants, receiver FSM encoding, counter helper
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_HLOCK  = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchronizer with a one-cycle falling-edge strobe
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= d;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign fall = sync_d & ~sync;

endmodule

// File: rtl/vga_rx.sv
// rtl/vga_rx.sv - VGA receiver: sync recovery, frame lock and visible-pixel coordinates
module vga_rx
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    parameter int V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    parameter int LOCK_LINES  = 4,
    parameter int H_VIS_START = H_SYNC + H_BACK,
    parameter int H_VIS_LEN   = H_VISIBLE,
    parameter int V_VIS_START = V_SYNC + V_BACK,
    parameter int V_VIS_LEN   = V_VISIBLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       r_in,
    input  logic       g_in,
    input  logic       b_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       valid,
    output logic [2:0] pix_rgb,
    output logic       newline,
    output logic       newframe,
    output logic       locked,
    output logic       timing_err,
    output logic [9:0] line_len
);

    // Assertion is immediate; release is re-timed so no flop leaves reset on a ragged edge.
    logic [1:0] rst_pipe;
    logic       rst_n_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_pipe <= 2'b00;
        else      rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n_sync = rst_pipe[1];

    logic h_fall;
    logic v_fall;

    sync_edge u_hsync (.clk(clk), .rst_n(rst_n_sync), .d(hsync_in), .fall(h_fall));
    sync_edge u_vsync (.clk(clk), .rst_n(rst_n_sync), .d(vsync_in), .fall(v_fall));

    logic [2:0] rgb_meta;
    logic [2:0] rgb_sync;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            rgb_meta <= 3'd0;
            rgb_sync <= 3'd0;
        end else begin
            rgb_meta <= {r_in, g_in, b_in};
            rgb_sync <= rgb_meta;
        end
    end

    logic [9:0] hcnt;
    logic       line_ok;

    assign line_ok = (sat_inc10(hcnt) == 10'(H_TOTAL));

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            hcnt     <= 10'd0;
            line_len <= 10'd0;
        end else if (h_fall) begin
            hcnt     <= 10'd0;
            line_len <= sat_inc10(hcnt);
        end else begin
            hcnt     <= sat_inc10(hcnt);
        end
    end

    rx_state_t  state;
    logic [7:0] good_cnt;
    logic [9:0] vcnt;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state      <= ST_SEARCH;
            good_cnt   <= 8'd0;
            vcnt       <= 10'd0;
            timing_err <= 1'b0;
        end else begin
            timing_err <= 1'b0;
            case (state)
                ST_SEARCH: begin
                    if (h_fall) begin
                        if (!line_ok) begin
                            good_cnt <= 8'd0;
                        end else if (good_cnt == 8'(LOCK_LINES - 1)) begin
                            good_cnt <= 8'd0;
                            state    <= ST_HLOCK;
                        end else begin
                            good_cnt <= good_cnt + 8'd1;
                        end
                    end
                end
                ST_HLOCK: begin
                    if (v_fall) begin
                        state <= ST_LOCKED;
                        vcnt  <= 10'd0;
                    end else if (h_fall && !line_ok) begin
                        state <= ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    // A vsync edge also closes the line that ended with it, so both periods are checked.
                    if (v_fall) begin
                        vcnt <= 10'd0;
                        if ((h_fall && !line_ok) || (sat_inc10(vcnt) != 10'(V_TOTAL))) begin
                            state      <= ST_SEARCH;
                            good_cnt   <= 8'd0;
                            timing_err <= 1'b1;
                        end
                    end else if (h_fall) begin
                        vcnt <= sat_inc10(vcnt);
                        if (!line_ok) begin
                            state      <= ST_SEARCH;
                            good_cnt   <= 8'd0;
                            timing_err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_SEARCH;
            endcase
        end
    end

    // hcnt trails the synchronized colour by one cycle (edge strobe stage), so decode on hcnt+1.
    logic [10:0] h_next;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic        in_win;

    assign h_next = {1'b0, hcnt} + 11'd1;
    assign x_next = 10'(h_next - 11'(H_VIS_START));
    assign y_next = vcnt - 10'(V_VIS_START);
    assign in_win = (state == ST_LOCKED)
                  && (h_next >= 11'(H_VIS_START)) && (h_next < 11'(H_VIS_START + H_VIS_LEN))
                  && (vcnt >= 10'(V_VIS_START)) && (vcnt < 10'(V_VIS_START + V_VIS_LEN));

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            x        <= 10'd0;
            y        <= 10'd0;
            valid    <= 1'b0;
            pix_rgb  <= 3'd0;
            newline  <= 1'b0;
            newframe <= 1'b0;
            locked   <= 1'b0;
        end else begin
            locked <= (state == ST_LOCKED);
            if (in_win) begin
                x        <= x_next;
                y        <= y_next;
                valid    <= 1'b1;
                pix_rgb  <= rgb_sync;
                newline  <= (x_next == 10'd0);
                newframe <= (x_next == 10'd0) && (y_next == 10'd0);
            end else begin
                x        <= 10'd0;
                y        <= 10'd0;
                valid    <= 1'b0;
                pix_rgb  <= 3'd0;
                newline  <= 1'b0;
                newframe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx.sv
// tb/tb_vga_rx.sv - scoreboard bench for vga_rx on a scaled-down raster
module tb_vga_rx;

    localparam int H_TOT    = 48;
    localparam int H_SYNC_W = 6;
    localparam int H_START  = 12;
    localparam int H_VIS    = 32;
    localparam int V_TOT    = 24;
    localparam int V_SYNC_W = 2;
    localparam int V_START  = 5;
    localparam int V_VIS    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       r_in = 1'b0;
    logic       g_in = 1'b0;
    logic       b_in = 1'b0;
    logic [9:0] x;
    logic [9:0] y;
    logic       valid;
    logic [2:0] pix_rgb;
    logic       newline;
    logic       newframe;
    logic       locked;
    logic       timing_err;
    logic [9:0] line_len;

    typedef struct {
        int stamp;
        int px;
        int py;
        int rgb;
    } pix_t;

    typedef struct {
        int stamp;
        int len;
    } err_t;

    pix_t sb[$];
    err_t eq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nl_cnt = 0;
    int nf_cnt = 0;
    int pix_cnt = 0;
    bit unlock_pending = 1'b0;

    vga_rx #(
        .H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .LOCK_LINES(4),
        .H_VIS_START(H_START), .H_VIS_LEN(H_VIS),
        .V_VIS_START(V_START), .V_VIS_LEN(V_VIS)
    ) dut (
        .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .x(x), .y(y), .valid(valid), .pix_rgb(pix_rgb),
        .newline(newline), .newframe(newframe), .locked(locked),
        .timing_err(timing_err), .line_len(line_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        pix_t e;
        err_t ee;
        if (unlock_pending) begin
            chk("unlock_next", locked, 1'b0);
            unlock_pending = 1'b0;
        end
        if (valid) begin
            pix_cnt++;
            chk("valid_locked", locked, 1'b1);
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("x", x, e.px);
                chk("y", y, e.py);
                chk("rgb", pix_rgb, e.rgb);
                chk("latency", cyc, e.stamp);
            end
        end else begin
            chk("idle_zero", {x, y, pix_rgb}, 0);
        end
        if (newline) begin
            nl_cnt++;
            chk("nl_at_x0", {valid, x}, {1'b1, 10'd0});
        end
        if (newframe) begin
            nf_cnt++;
            chk("nf_with_nl", {newline, y}, {1'b1, 10'd0});
        end
        if (timing_err) begin
            chk("err_expected", eq.size() != 0, 1'b1);
            chk("lock_at_err", locked, 1'b1);
            if (eq.size() != 0) begin
                ee = eq.pop_front();
                chk("err_time", cyc, ee.stamp);
                chk("err_len", line_len, ee.len);
            end
            unlock_pending = 1'b1;
        end
    end

    task automatic drive_frame(input int n_lines, input int short_row, input int exp_lo,
                               input int exp_hi, input bit err_at_start, input int rst_row,
                               input int rst_col, input bit lock_end);
        int   base_nl = nl_cnt;
        int   base_nf = nf_cnt;
        int   base_pix = pix_cnt;
        int   e_nl = 0;
        int   e_nf = 0;
        int   e_pix = 0;
        bit   cut = 1'b0;
        int   len;
        pix_t p;
        err_t ee;
        for (int r = 0; r < n_lines; r++) begin
            len = (r == short_row) ? H_TOT - 1 : H_TOT;
            for (int c = 0; c < len; c++) begin
                @(posedge clk);
                #1;
                hsync_in = (c >= H_SYNC_W);
                vsync_in = (r >= V_SYNC_W);
                if (c == 0 && r == 0 && err_at_start) begin
                    ee.stamp = cyc + 3;
                    ee.len   = H_TOT;
                    eq.push_back(ee);
                end
                if (c == 0 && short_row >= 0 && r == short_row + 1) begin
                    ee.stamp = cyc + 3;
                    ee.len   = H_TOT - 1;
                    eq.push_back(ee);
                end
                if (r == rst_row && c == rst_col) begin
                    rst = 1'b0;
                    cut = 1'b1;
                    #1;
                    chk("rst_async_zero", {x, y, valid, pix_rgb, newline, newframe,
                                           locked, timing_err, line_len}, 0);
                    while (sb.size() != 0) begin
                        p = sb[sb.size() - 1];
                        if (p.stamp < cyc) break;
                        e_pix--;
                        if (p.px == 0) begin
                            e_nl--;
                            if (p.py == 0) e_nf--;
                        end
                        void'(sb.pop_back());
                    end
                end
                if (r == rst_row && c == rst_col + 3) rst = 1'b1;
                if (r >= V_START && r < V_START + V_VIS && c >= H_START && c < H_START + H_VIS) begin
                    p.px    = c - H_START;
                    p.py    = r - V_START;
                    p.rgb   = p.px % 8;
                    p.stamp = cyc + 3;
                    {r_in, g_in, b_in} = 3'(p.px);
                    if (!cut && r >= exp_lo && r <= exp_hi) begin
                        sb.push_back(p);
                        e_pix++;
                        if (p.px == 0) begin
                            e_nl++;
                            if (p.py == 0) e_nf++;
                        end
                    end
                end else begin
                    {r_in, g_in, b_in} = 3'($urandom_range(0, 7));
                end
            end
        end
        chk("frame_pix", pix_cnt - base_pix, e_pix);
        chk("frame_newline", nl_cnt - base_nl, e_nl);
        chk("frame_newframe", nf_cnt - base_nf, e_nf);
        chk("lock_end", locked, lock_end);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_valid", valid, 0);
        chk("rst_rgb", pix_rgb, 0);
        chk("rst_newline", newline, 0);
        chk("rst_newframe", newframe, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timing_err", timing_err, 0);
        chk("rst_line_len", line_len, 0);
        rst = 1'b1;

        // hsync stuck high, then one well-formed line
        repeat (2000) @(posedge clk);
        for (int c = 0; c < H_TOT; c++) begin
            @(posedge clk);
            #1;
            hsync_in = (c >= H_SYNC_W);
        end
        chk("line_len_sat", line_len, 10'd1023);
        chk("sat_no_lock", locked, 0);

        drive_frame(V_TOT,     -1, 1, 0,     1'b0, -1, -1, 1'b0);
        drive_frame(V_TOT,     -1, 0, V_TOT, 1'b0, -1, -1, 1'b1);
        drive_frame(V_TOT,     -1, 0, V_TOT, 1'b0, -1, -1, 1'b1);
        drive_frame(V_TOT,      8, 0, 8,     1'b0, -1, -1, 1'b0);
        drive_frame(V_TOT,     -1, 0, V_TOT, 1'b0, -1, -1, 1'b1);
        drive_frame(V_TOT - 1, -1, 0, V_TOT, 1'b0, -1, -1, 1'b1);
        drive_frame(V_TOT,     -1, 1, 0,     1'b1, -1, -1, 1'b0);
        drive_frame(V_TOT,     -1, 0, V_TOT, 1'b0, -1, -1, 1'b1);
        drive_frame(V_TOT,     -1, 0, V_TOT, 1'b0, 10, H_START + 10, 1'b0);
        drive_frame(V_TOT,     -1, 0, V_TOT, 1'b0, -1, -1, 1'b1);

        repeat (10) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        chk("errq_drained", eq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
